// File: rtl/ahb5_apb4_bridge_mp_if.sv
// Signal bundle for the multi-port AHB5-to-APB4 bridge.
// Holds the per-port AHB subordinate signals and the single APB4 requester.
interface ahb5_apb4_bridge_mp_if #(
  parameter int NUM_AHB = 2,
  parameter int ADDR_W  = 32
);
  logic [NUM_AHB-1:0]             HSEL;
  logic [NUM_AHB-1:0][ADDR_W-1:0] HADDR;
  logic [NUM_AHB-1:0][1:0]        HTRANS;
  logic [NUM_AHB-1:0]             HWRITE;
  logic [NUM_AHB-1:0][2:0]        HSIZE;
  logic [NUM_AHB-1:0][3:0]        HPROT;
  logic [NUM_AHB-1:0]             HNONSEC;
  logic [NUM_AHB-1:0][31:0]       HWDATA;
  logic [NUM_AHB-1:0]             HREADY;
  logic [NUM_AHB-1:0]             HREADYOUT;
  logic [NUM_AHB-1:0]             HRESP;
  logic [NUM_AHB-1:0][31:0]       HRDATA;

  logic [ADDR_W-1:0] PADDR;
  logic              PSEL;
  logic              PENABLE;
  logic              PWRITE;
  logic [31:0]       PWDATA;
  logic [3:0]        PSTRB;
  logic [2:0]        PPROT;
  logic [31:0]       PRDATA;
  logic              PREADY;
  logic              PSLVERR;

  modport slave (
    input  HSEL, HADDR, HTRANS, HWRITE, HSIZE, HPROT, HNONSEC, HWDATA, HREADY,
    output HREADYOUT, HRESP, HRDATA,
    output PADDR, PSEL, PENABLE, PWRITE, PWDATA, PSTRB, PPROT,
    input  PRDATA, PREADY, PSLVERR
  );

  modport master (
    output HSEL, HADDR, HTRANS, HWRITE, HSIZE, HPROT, HNONSEC, HWDATA, HREADY,
    input  HREADYOUT, HRESP, HRDATA,
    input  PADDR, PSEL, PENABLE, PWRITE, PWDATA, PSTRB, PPROT,
    output PRDATA, PREADY, PSLVERR
  );
endinterface

// File: rtl/ahb5_apb4_bridge_mp.sv
// Multi-port AHB5-to-APB4 bridge: each AHB port captures one transfer and stalls its master,
// an arbiter serialises pending transfers onto one APB4 requester with error/timeout mapping.
//
// state     | meaning
// IDLE      | arbitrate over pending ports, register APB address/control/data
// SETUP     | PSEL=1, PENABLE=0, load timeout counter
// ACCESS    | PSEL=1, PENABLE=1, wait for PREADY or timeout
// RESP      | OKAY response (HREADYOUT=1) to granted port
// ERR1      | first ERROR cycle (HRESP=1, HREADYOUT=0)
// ERR2      | second ERROR cycle (HRESP=1, HREADYOUT=1)
module ahb5_apb4_bridge_mp #(
  parameter int NUM_AHB     = 2,
  parameter int ADDR_W      = 32,
  parameter int ARB_MODE    = 0,
  parameter int TIMEOUT_CYC = 0
) (
  input logic HCLK,
  input logic HRESETn,
  ahb5_apb4_bridge_mp_if.slave bus
);
  localparam int IW = (NUM_AHB > 1) ? $clog2(NUM_AHB) : 1;
  localparam int TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_SETUP  = 3'd1;
  localparam logic [2:0] ST_ACCESS = 3'd2;
  localparam logic [2:0] ST_RESP   = 3'd3;
  localparam logic [2:0] ST_ERR1   = 3'd4;
  localparam logic [2:0] ST_ERR2   = 3'd5;

  logic [2:0]                     state;
  logic [IW-1:0]                  gnt, rr_ptr, arb_idx;
  logic [TW-1:0]                  tmo_cnt;
  logic [NUM_AHB-1:0]             pending;
  logic [NUM_AHB-1:0][ADDR_W-1:0] cap_addr;
  logic [NUM_AHB-1:0]             cap_write;
  logic [NUM_AHB-1:0][1:0]        cap_size;
  logic [NUM_AHB-1:0][2:0]        cap_prot;
  logic [NUM_AHB-1:0][1:0]        loc_err;
  logic [NUM_AHB-1:0]             cap_req, cap_bad;

  logic [NUM_AHB-1:0]       hreadyout_q, hresp_q;
  logic [NUM_AHB-1:0][31:0] hrdata_q;
  logic [ADDR_W-1:0]        paddr_q;
  logic                     psel_q, penable_q, pwrite_q;
  logic [31:0]              pwdata_q;
  logic [3:0]               pstrb_q;
  logic [2:0]               pprot_q;

  logic tmo_hit, acc_ok, acc_fail;

  wire unused_bits = ^{bus.HTRANS, bus.HPROT};

  assign bus.HREADYOUT = hreadyout_q;
  assign bus.HRESP     = hresp_q;
  assign bus.HRDATA    = hrdata_q;
  assign bus.PADDR     = paddr_q;
  assign bus.PSEL      = psel_q;
  assign bus.PENABLE   = penable_q;
  assign bus.PWRITE    = pwrite_q;
  assign bus.PWDATA    = pwdata_q;
  assign bus.PSTRB     = pstrb_q;
  assign bus.PPROT     = pprot_q;

  function automatic logic [3:0] strb_of(input logic wr, input logic [1:0] sz, input logic [1:0] a);
    if (!wr) return 4'b0000;
    case (sz)
      2'd0:    return 4'b0001 << a;
      2'd1:    return a[1] ? 4'b1100 : 4'b0011;
      default: return 4'b1111;
    endcase
  endfunction

  always_comb begin
    cap_req = '0;
    cap_bad = '0;
    for (int i = 0; i < NUM_AHB; i++) begin
      cap_req[i] = bus.HSEL[i] & bus.HTRANS[i][1] & bus.HREADY[i];
      cap_bad[i] = (bus.HSIZE[i] > 3'd2) ||
                   (bus.HSIZE[i] == 3'd1 && bus.HADDR[i][0]) ||
                   (bus.HSIZE[i] == 3'd2 && bus.HADDR[i][1:0] != 2'b00);
    end
  end

  // Later loop iterations overwrite earlier ones, so iterate from lowest to highest priority.
  always_comb begin
    arb_idx = '0;
    if (ARB_MODE == 1) begin
      for (int k = NUM_AHB - 1; k >= 0; k--)
        if (pending[k]) arb_idx = IW'(k);
    end else begin
      for (int k = NUM_AHB; k >= 1; k--)
        if (pending[(int'(rr_ptr) + k) % NUM_AHB]) arb_idx = IW'((int'(rr_ptr) + k) % NUM_AHB);
    end
  end

  assign tmo_hit  = (TIMEOUT_CYC != 0) && (tmo_cnt == '0);
  assign acc_ok   = (state == ST_ACCESS) && bus.PREADY && !bus.PSLVERR;
  assign acc_fail = (state == ST_ACCESS) && (bus.PREADY ? bus.PSLVERR : tmo_hit);

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state     <= ST_IDLE;
      gnt       <= '0;
      rr_ptr    <= IW'(NUM_AHB - 1);
      tmo_cnt   <= '0;
      paddr_q   <= '0;
      psel_q    <= 1'b0;
      penable_q <= 1'b0;
      pwrite_q  <= 1'b0;
      pwdata_q  <= '0;
      pstrb_q   <= '0;
      pprot_q   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (|pending) begin
            gnt <= arb_idx;
            if (ARB_MODE == 0) rr_ptr <= arb_idx;
            paddr_q  <= cap_addr[arb_idx];
            pwrite_q <= cap_write[arb_idx];
            pprot_q  <= cap_prot[arb_idx];
            pstrb_q  <= strb_of(cap_write[arb_idx], cap_size[arb_idx], cap_addr[arb_idx][1:0]);
            pwdata_q <= bus.HWDATA[arb_idx];
            psel_q   <= 1'b1;
            state    <= ST_SETUP;
          end
        end
        ST_SETUP: begin
          penable_q <= 1'b1;
          tmo_cnt   <= TW'(TIMEOUT_CYC - 1);
          state     <= ST_ACCESS;
        end
        ST_ACCESS: begin
          if (acc_ok || acc_fail) begin
            psel_q    <= 1'b0;
            penable_q <= 1'b0;
            state     <= acc_ok ? ST_RESP : ST_ERR1;
          end else if (tmo_cnt != '0) begin
            tmo_cnt <= tmo_cnt - 1'b1;
          end
        end
        ST_RESP: state <= ST_IDLE;
        ST_ERR1: state <= ST_ERR2;
        ST_ERR2: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Capture is last so a new address phase in a RESP/ERR2 cycle wins over the response teardown.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      pending     <= '0;
      hreadyout_q <= '1;
      hresp_q     <= '0;
      hrdata_q    <= '0;
      loc_err     <= '0;
      cap_addr    <= '0;
      cap_write   <= '0;
      cap_size    <= '0;
      cap_prot    <= '0;
    end else begin
      for (int i = 0; i < NUM_AHB; i++) begin
        hrdata_q[i] <= '0;
        if (loc_err[i] == 2'd1) begin
          hreadyout_q[i] <= 1'b1;
          loc_err[i]     <= 2'd2;
        end else if (loc_err[i] == 2'd2) begin
          hresp_q[i] <= 1'b0;
          loc_err[i] <= 2'd0;
        end
        if (gnt == IW'(i)) begin
          if (acc_ok) begin
            hreadyout_q[i] <= 1'b1;
            hresp_q[i]     <= 1'b0;
            pending[i]     <= 1'b0;
            if (!cap_write[i]) hrdata_q[i] <= bus.PRDATA;
          end else if (acc_fail) begin
            hresp_q[i] <= 1'b1;
          end else if (state == ST_ERR1) begin
            hreadyout_q[i] <= 1'b1;
            pending[i]     <= 1'b0;
          end else if (state == ST_ERR2) begin
            hresp_q[i] <= 1'b0;
          end
        end
        if (cap_req[i]) begin
          hreadyout_q[i] <= 1'b0;
          if (cap_bad[i]) begin
            hresp_q[i] <= 1'b1;
            loc_err[i] <= 2'd1;
          end else begin
            hresp_q[i]   <= 1'b0;
            pending[i]   <= 1'b1;
            cap_addr[i]  <= bus.HADDR[i];
            cap_write[i] <= bus.HWRITE[i];
            cap_size[i]  <= bus.HSIZE[i][1:0];
            cap_prot[i]  <= {~bus.HPROT[i][0], bus.HNONSEC[i], bus.HPROT[i][1]};
          end
        end
      end
    end
  end
endmodule
